// File: rtl/if_fetch_stage.sv
// LoongArch IF stage: owns fs_pc and keeps one SRAM-like read in flight; IF_ADEF_CHECK_EN enables misaligned-PC (adef) packets.
// Latency: addr_ok in N, data_ok in N+1, packet valid in N+2; the packet is held until ds_allowin or a redirect drops it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  input  logic        wb_ex,
  input  logic [31:0] csr_eentry,
  input  logic        wb_ertn,
  input  logic [31:0] csr_era,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_pkt_t;

`ifdef IF_ADEF_CHECK_EN
  localparam logic ADEF_EN = 1'b1;
`else
  localparam logic ADEF_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        adef_buf_q, adef_buf_d;
  logic        discard_q, discard_d;

  logic        redir;
  logic [31:0] redir_target;
  logic        pc_misaligned;
  logic        req;
  fs_pkt_t     pkt;

  assign redir = wb_ex | wb_ertn | br_bus[32];

  always_comb begin
    redir_target = br_bus[31:0];
    if (wb_ex) begin
      redir_target = csr_eentry;
    end else if (wb_ertn) begin
      redir_target = csr_era;
    end
  end

  assign pc_misaligned = ADEF_EN & (fs_pc_q[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    fs_pc_d    = fs_pc_q;
    inst_buf_d = inst_buf_q;
    adef_buf_d = adef_buf_q;
    discard_d  = discard_q;
    pend_pc_d  = pend_pc_q;
    req        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pc_misaligned) begin
          if (redir) begin
            fs_pc_d = redir_target;
          end else begin
            state_d    = S_HOLD;
            adef_buf_d = 1'b1;
            inst_buf_d = 32'h0;
          end
        end else begin
          // The request address stays fixed until accepted; a redirect only marks the reply stale.
          req = 1'b1;
          if (redir) begin
            discard_d = 1'b1;
            pend_pc_d = redir_target;
          end
          if (inst_sram_addr_ok) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (redir) begin
            fs_pc_d = redir_target;
          end else if (discard_q) begin
            fs_pc_d = pend_pc_q;
          end else begin
            state_d    = S_HOLD;
            inst_buf_d = inst_sram_rdata;
            adef_buf_d = 1'b0;
          end
        end else if (redir) begin
          discard_d = 1'b1;
          pend_pc_d = redir_target;
        end
      end
      S_HOLD: begin
        if (redir) begin
          fs_pc_d = redir_target;
          state_d = S_IDLE;
        end else if (ds_allowin) begin
          fs_pc_d = fs_pc_q + 32'd4;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fs_pc_q    <= RESET_PC;
      inst_buf_q <= 32'h0;
      adef_buf_q <= 1'b0;
      discard_q  <= 1'b0;
      pend_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fs_pc_q    <= fs_pc_d;
      inst_buf_q <= inst_buf_d;
      adef_buf_q <= adef_buf_d;
      discard_q  <= discard_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign pkt.adef = ADEF_EN & adef_buf_q;
  assign pkt.inst = inst_buf_q;
  assign pkt.pc   = fs_pc_q;

  assign fs_to_ds_valid  = (state_q == S_HOLD) & ~redir;
  assign fs_to_ds_bus    = (state_q == S_HOLD) ? pkt : 65'h0;

  // Gated by resetn so the port is quiet while the memory side is also in reset.
  assign inst_sram_req   = req & resetn;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = ADEF_EN ? fs_pc_q : {fs_pc_q[31:2], 2'b00};
  assign inst_sram_wdata = 32'h0;

endmodule
